ex_wb_collector: RTL and testbench

Write-back collector directly downstream of the execute stage. It takes the independent result streams that execute produces (fixed-latency unit, load, store, FPU), buffers each in a small per-source FIFO, and arbitrates them round-robin onto NR_WB_PORTS scoreboard write ports. It also returns per-source almost-full flags so issue can throttle.

---
 rtl/ex_wb_collector.sv | 161 ++++++++++++++++
 tb/tb_ex_wb_collector.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_collector.sv
// Write-back collector: buffers each execute result stream in a small FIFO and
// drains the FIFO heads round-robin onto the scoreboard write ports.
module ex_wb_collector #(
  parameter int unsigned NR_SRC        = 4,
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_i,
  input  logic [NR_SRC-1:0]                           src_valid_i,
  input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]        src_trans_id_i,
  input  logic [NR_SRC-1:0][XLEN-1:0]                 src_result_i,
  input  logic [NR_SRC-1:0]                           src_ex_valid_i,
  input  logic [NR_SRC-1:0][XLEN-1:0]                 src_ex_cause_i,
  input  logic [NR_SRC-1:0][XLEN-1:0]                 src_ex_tval_i,
  output logic [NR_SRC-1:0]                           src_afull_o,
  output logic [NR_WB_PORTS-1:0]                      wb_valid_o,
  output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [NR_WB_PORTS-1:0][XLEN-1:0]            wb_result_o,
  output logic [NR_WB_PORTS-1:0]                      wb_ex_valid_o,
  output logic [NR_WB_PORTS-1:0][XLEN-1:0]            wb_ex_cause_o,
  output logic [NR_WB_PORTS-1:0][XLEN-1:0]            wb_ex_tval_o,
  output logic                                        overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - 1);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    logic                     ex_valid;
    logic [XLEN-1:0]          cause;
    logic [XLEN-1:0]          tval;
  } entry_t;

  entry_t                 head     [NR_SRC];
  logic [CNT_W-1:0]       cnt      [NR_SRC];
  logic [NR_SRC-1:0]      push;
  logic [NR_SRC-1:0]      pop;
  logic [NR_SRC-1:0]      accept;
  logic [NR_SRC-1:0]      drop;

  logic [SRC_W-1:0]       rr_q;
  logic [SRC_W-1:0]       last_src;
  logic [SRC_W-1:0]       scan_idx;
  int                     n_grant;
  logic                   overflow_q;

  logic [NR_WB_PORTS-1:0] port_vld;
  logic [SRC_W-1:0]       port_src [NR_WB_PORTS];

  // Stage 0: per-source circular FIFOs; pushes during flush are discarded
  for (genvar s = 0; s < NR_SRC; s++) begin : g_fifo
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             full;
    entry_t           din;

    assign din = '{trans_id: src_trans_id_i[s],
                   result:   src_result_i[s],
                   ex_valid: src_ex_valid_i[s],
                   cause:    src_ex_cause_i[s],
                   tval:     src_ex_tval_i[s]};

    assign full      = (cnt_q == FULL_CNT);
    assign push[s]   = src_valid_i[s] & ~flush_i;
    // A full FIFO still takes the push when its head leaves in the same cycle.
    assign accept[s] = push[s] & (~full | pop[s]);
    assign drop[s]   = push[s] & full & ~pop[s];

    assign head[s]        = mem_q[rd_ptr_q];
    assign cnt[s]         = cnt_q;
    assign src_afull_o[s] = (cnt_q >= AFULL_CNT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (accept[s]) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop[s])    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (accept[s] && !pop[s])      cnt_q <= cnt_q + CNT_W'(1);
        else if (!accept[s] && pop[s]) cnt_q <= cnt_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (accept[s]) mem_q[wr_ptr_q] <= din;
    end
  end

  // Stage 1: round-robin grant of non-empty FIFO heads to write ports
  always_comb begin
    pop      = '0;
    port_vld = '0;
    last_src = rr_q;
    scan_idx = '0;
    n_grant  = 0;
    for (int p = 0; p < int'(NR_WB_PORTS); p++) port_src[p] = '0;
    for (int k = 0; k < int'(NR_SRC); k++) begin
      scan_idx = SRC_W'((int'(rr_q) + k) % int'(NR_SRC));
      if (!flush_i && (cnt[scan_idx] != '0) && (n_grant < int'(NR_WB_PORTS))) begin
        pop[scan_idx] = 1'b1;
        for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
          if (n_grant == p) begin
            port_vld[p] = 1'b1;
            port_src[p] = scan_idx;
          end
        end
        last_src = scan_idx;
        n_grant  = n_grant + 1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (|pop)  rr_q       <= SRC_W'((int'(last_src) + 1) % int'(NR_SRC));
      if (|drop) overflow_q <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;

  // Ungranted ports are driven to zero so stale heads never leak out.
  always_comb begin
    for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
      wb_valid_o[p]    = port_vld[p];
      wb_trans_id_o[p] = '0;
      wb_result_o[p]   = '0;
      wb_ex_valid_o[p] = 1'b0;
      wb_ex_cause_o[p] = '0;
      wb_ex_tval_o[p]  = '0;
      if (port_vld[p]) begin
        wb_trans_id_o[p] = head[port_src[p]].trans_id;
        wb_result_o[p]   = head[port_src[p]].result;
        wb_ex_valid_o[p] = head[port_src[p]].ex_valid;
        wb_ex_cause_o[p] = head[port_src[p]].cause;
        wb_ex_tval_o[p]  = head[port_src[p]].tval;
      end
    end
  end

endmodule

// File: tb/tb_ex_wb_collector.sv
// Directed bench for ex_wb_collector: a 2-port and a 1-port instance share stimulus.
module tb_ex_wb_collector;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i;
  logic [3:0]        src_valid;
  logic [3:0][2:0]   src_tid;
  logic [3:0][63:0]  src_res;
  logic [3:0]        src_exv;
  logic [3:0][63:0]  src_cause;
  logic [3:0][63:0]  src_tval;

  logic [3:0]        afull0;
  logic [1:0]        wbv0;
  logic [1:0][2:0]   wbt0;
  logic [1:0][63:0]  wbr0;
  logic [1:0]        wbe0;
  logic [1:0][63:0]  wbc0;
  logic [1:0][63:0]  wbtv0;
  logic              ov0;

  logic [3:0]        afull1;
  logic [0:0]        wbv1;
  logic [0:0][2:0]   wbt1;
  logic [0:0][63:0]  wbr1;
  logic [0:0]        wbe1;
  logic [0:0][63:0]  wbc1;
  logic [0:0][63:0]  wbtv1;
  logic              ov1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ex_wb_collector #(.NR_SRC(4), .NR_WB_PORTS(2), .DEPTH(2), .XLEN(64), .TRANS_ID_BITS(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .src_valid_i(src_valid), .src_trans_id_i(src_tid), .src_result_i(src_res),
    .src_ex_valid_i(src_exv), .src_ex_cause_i(src_cause), .src_ex_tval_i(src_tval),
    .src_afull_o(afull0), .wb_valid_o(wbv0), .wb_trans_id_o(wbt0), .wb_result_o(wbr0),
    .wb_ex_valid_o(wbe0), .wb_ex_cause_o(wbc0), .wb_ex_tval_o(wbtv0), .overflow_o(ov0)
  );

  ex_wb_collector #(.NR_SRC(4), .NR_WB_PORTS(1), .DEPTH(2), .XLEN(64), .TRANS_ID_BITS(3)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .src_valid_i(src_valid), .src_trans_id_i(src_tid), .src_result_i(src_res),
    .src_ex_valid_i(src_exv), .src_ex_cause_i(src_cause), .src_ex_tval_i(src_tval),
    .src_afull_o(afull1), .wb_valid_o(wbv1), .wb_trans_id_o(wbt1), .wb_result_o(wbr1),
    .wb_ex_valid_o(wbe1), .wb_ex_cause_o(wbc1), .wb_ex_tval_o(wbtv1), .overflow_o(ov1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic clr();
    flush_i   = 1'b0;
    src_valid = '0;
    src_tid   = '0;
    src_res   = '0;
    src_exv   = '0;
    src_cause = '0;
    src_tval  = '0;
  endtask

  task automatic push(input int s, input int tid, input logic [63:0] res);
    src_valid[s] = 1'b1;
    src_tid[s]   = 3'(tid);
    src_res[s]   = res;
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
    clr();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clr();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    clr();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("rst_wb_valid", 64'(wbv0), 64'h0);
    chk("rst_afull", 64'(afull0), 64'h0);
    chk("rst_overflow", 64'(ov0), 64'h0);
    chk("rst_wb_result", wbr0[0], 64'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // four sources push at once, rr_ptr = 0
    for (int s = 0; s < 4; s++) push(s, s, 64'h100 + 64'(s));
    @(negedge clk_i);
    chk("four_no_bypass", 64'(wbv0), 64'h0);
    next();
    @(negedge clk_i);
    chk("four_c1_valid", 64'(wbv0), 64'h3);
    chk("four_c1_id0", 64'(wbt0[0]), 64'h0);
    chk("four_c1_id1", 64'(wbt0[1]), 64'h1);
    chk("four_c1_res0", wbr0[0], 64'h100);
    chk("four_c1_res1", wbr0[1], 64'h101);
    chk("four_c1_afull", 64'(afull0), 64'hF);
    next();
    @(negedge clk_i);
    chk("four_c2_valid", 64'(wbv0), 64'h3);
    chk("four_c2_id0", 64'(wbt0[0]), 64'h2);
    chk("four_c2_id1", 64'(wbt0[1]), 64'h3);
    chk("four_c2_afull", 64'(afull0), 64'hC);
    next();
    push(0, 4, 64'h200);
    push(3, 7, 64'h203);
    @(negedge clk_i);
    chk("four_c3_valid", 64'(wbv0), 64'h0);
    chk("four_c3_afull", 64'(afull0), 64'h0);
    next();
    @(negedge clk_i);
    chk("rr_wrap_valid", 64'(wbv0), 64'h3);
    chk("rr_wrap_id0", 64'(wbt0[0]), 64'h4);
    chk("rr_wrap_id1", 64'(wbt0[1]), 64'h7);

    // single load push
    do_reset();
    push(1, 5, 64'hDEAD_BEEF);
    @(negedge clk_i);
    chk("load_no_bypass", 64'(wbv0), 64'h0);
    next();
    @(negedge clk_i);
    chk("load_valid", 64'(wbv0), 64'h1);
    chk("load_id", 64'(wbt0[0]), 64'h5);
    chk("load_res", wbr0[0], 64'hDEAD_BEEF);
    chk("load_exv", 64'(wbe0), 64'h0);
    chk("load_port1_zero", wbr0[1], 64'h0);
    chk("load_afull", 64'(afull0), 64'h2);
    next();
    @(negedge clk_i);
    chk("load_n2_valid", 64'(wbv0), 64'h0);
    chk("load_n2_res", wbr0[0], 64'h0);
    chk("load_n2_afull", 64'(afull0), 64'h0);

    // back-to-back FLU pushes on the single-port instance
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) push(0, i, 64'h10 + 64'(i));
      @(negedge clk_i);
      if (i == 1) chk("flu_no_bypass", 64'(wbv1), 64'h0);
      else begin
        chk("flu_valid", 64'(wbv1), 64'h1);
        chk("flu_id", 64'(wbt1[0]), 64'(i - 1));
        chk("flu_res", wbr1[0], 64'h10 + 64'(i - 1));
        chk("flu_afull", 64'(afull1), 64'h1);
        chk("flu_overflow", 64'(ov1), 64'h0);
      end
      next();
    end
    @(negedge clk_i);
    chk("flu_end_valid", 64'(wbv1), 64'h0);
    chk("flu_end_afull", 64'(afull1), 64'h0);
    chk("flu_end_overflow", 64'(ov1), 64'h0);

    // starve source 3 on the single-port instance until it overflows
    do_reset();
    push(0, 0, 64'h300);
    push(1, 1, 64'h301);
    push(3, 3, 64'h331);
    @(negedge clk_i);
    next();
    push(3, 5, 64'h332);
    @(negedge clk_i);
    chk("ovf_c1_id", 64'(wbt1[0]), 64'h0);
    chk("ovf_c1_afull", 64'(afull1), 64'hB);
    chk("ovf_c1_overflow", 64'(ov1), 64'h0);
    next();
    push(3, 6, 64'h333);
    @(negedge clk_i);
    chk("ovf_c2_id", 64'(wbt1[0]), 64'h1);
    chk("ovf_c2_afull", 64'(afull1), 64'hA);
    chk("ovf_c2_overflow", 64'(ov1), 64'h0);
    next();
    @(negedge clk_i);
    chk("ovf_c3_overflow", 64'(ov1), 64'h1);
    chk("ovf_c3_id", 64'(wbt1[0]), 64'h3);
    chk("ovf_c3_res", wbr1[0], 64'h331);
    chk("ovf_c3_afull", 64'(afull1), 64'h8);
    next();
    @(negedge clk_i);
    chk("ovf_c4_id", 64'(wbt1[0]), 64'h5);
    chk("ovf_c4_res", wbr1[0], 64'h332);
    next();
    @(negedge clk_i);
    chk("ovf_c5_valid", 64'(wbv1), 64'h0);
    chk("ovf_c5_overflow", 64'(ov1), 64'h1);
    chk("ovf_c5_afull", 64'(afull1), 64'h0);

    // flush with two entries queued and pushes in the flush cycle
    do_reset();
    push(0, 1, 64'h401);
    push(1, 2, 64'h402);
    @(negedge clk_i);
    next();
    flush_i = 1'b1;
    push(2, 3, 64'h403);
    push(3, 4, 64'h404);
    @(negedge clk_i);
    chk("flush_valid", 64'(wbv0), 64'h0);
    chk("flush_valid_1p", 64'(wbv1), 64'h0);
    chk("flush_afull_pre", 64'(afull0), 64'h3);
    next();
    push(0, 5, 64'h405);
    push(3, 6, 64'h406);
    @(negedge clk_i);
    chk("flush_n1_valid", 64'(wbv0), 64'h0);
    chk("flush_n1_afull", 64'(afull0), 64'h0);
    next();
    @(negedge clk_i);
    chk("flush_n2_valid", 64'(wbv0), 64'h3);
    chk("flush_n2_id0", 64'(wbt0[0]), 64'h5);
    chk("flush_n2_id1", 64'(wbt0[1]), 64'h6);
    chk("flush_n2_res1", wbr0[1], 64'h406);

    // FPU exception result
    do_reset();
    push(3, 7, 64'h99);
    src_exv[3]   = 1'b1;
    src_cause[3] = 64'h2;
    src_tval[3]  = 64'h1234;
    @(negedge clk_i);
    next();
    @(negedge clk_i);
    chk("exc_valid", 64'(wbv0), 64'h1);
    chk("exc_exv", 64'(wbe0), 64'h1);
    chk("exc_cause", wbc0[0], 64'h2);
    chk("exc_tval", wbtv0[0], 64'h1234);
    chk("exc_id", 64'(wbt0[0]), 64'h7);
    chk("exc_res", wbr0[0], 64'h99);
    chk("exc_port1_cause", wbc0[1], 64'h0);
    chk("exc_port1_tval", wbtv0[1], 64'h0);
    chk("exc_1p_exv", 64'(wbe1), 64'h1);
    chk("exc_1p_cause", wbc1[0], 64'h2);
    chk("exc_1p_tval", wbtv1[0], 64'h1234);
    next();
    @(negedge clk_i);
    chk("exc_n2_exv", 64'(wbe0), 64'h0);
    chk("exc_n2_cause", wbc0[0], 64'h0);

    // asynchronous reset while entries are queued
    push(0, 1, 64'h501);
    push(1, 2, 64'h502);
    @(negedge clk_i);
    next();
    @(negedge clk_i);
    chk("areset_pre_valid", 64'(wbv0), 64'h3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("areset_valid", 64'(wbv0), 64'h0);
    chk("areset_afull", 64'(afull0), 64'h0);
    chk("areset_res", wbr0[0], 64'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("areset_post_valid", 64'(wbv0), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
